cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Memory-side refill engine for the 4096-entry direct-mapped data cache. When the cache reports a miss, it fetches the 4-word block that contains the missing address from main memory, one word per memory handshake. It then presents the block on four data buses with a single-cycle write strobe so the cache installs all four entries together. While a refill is in flight it stalls the processor and counts completed refills.

## Interface
Parameters:
- ADDR_W, 15, word address width (3-bit tag + 12-bit index)
- DATA_W, 32, word width
- CNT_W, 16, refill counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- miss  in  1  cache miss flag, registered by the cache
- address  in  ADDR_W  processor word address, held stable while stall=1
- mem_req  out  1  read request to main memory
- mem_addr  out  ADDR_W  word address of the current memory read
- mem_ack  in  1  memory has valid mem_rdata this cycle
- mem_rdata  in  DATA_W  memory read data
- data1, data2, data3, data4  out  DATA_W  block words at offsets 0..3
- write  out  1  one-cycle strobe; cache writes data1..data4 at base..base+3
- stall  out  1  processor hold while a refill is in progress
- busy  out  1  FSM not in IDLE
- fill_count  out  CNT_W  completed refills, saturating

## Operation
- FSM states: IDLE, FETCH, WRITE, SETTLE.
- IDLE: if miss=1 at a rising edge:
  - latch base = {address[14:2], 2'b00}
  - clear word index idx to 0
  - go to FETCH
- FETCH:
  - mem_req=1 and mem_addr=base+idx, held until acknowledged.
  - On an edge with mem_ack=1, capture mem_rdata into word slot idx.
  - If idx=3, go to WRITE; otherwise increment idx.
  - mem_req stays high across consecutive words; mem_addr changes only after an ack.
- WRITE:
  - write=1 for exactly one cycle; data1..data4 show the captured words.
  - fill_count increments, saturating at all-ones.
  - Then go to SETTLE.
- SETTLE: one cycle with stall=1 so the cache re-evaluates hit on the refilled line. miss is ignored. Go to IDLE.
- Address arithmetic: base+idx never carries out of bits [1:0], so a block never crosses an index boundary. Block base 0x7FFC fetches 0x7FFC..0x7FFF with no wrap.
- Ignored inputs:
  - mem_ack outside FETCH
  - miss outside IDLE
  - address changes after the latch
- data1..data4 hold the last refill until the next refill overwrites them slot by slot.
- Combinational outputs:
  - stall = busy = (state != IDLE)
  - mem_req = (state == FETCH)
  - mem_addr = 0 when not in FETCH
- No abort input; a started refill always completes unless reset.

## Timing
- Reset values (applied immediately, independent of clk):
  - state=IDLE, idx=0, base=0
  - mem_req=0, mem_addr=0, write=0, stall=0, busy=0
  - data1..data4=0, fill_count=0
- Reset mid-refill: the FSM returns to IDLE immediately. No write pulse, partial words cleared, fill_count=0.
- Zero-wait memory (mem_ack tied 1), miss seen at edge E0:
  - FETCH during E0–E4, words captured at E1..E4
  - write high during E4–E5
  - SETTLE during E5–E6
  - IDLE after E6
  - stall high for 6 cycles
- Wait states add cycles one-for-one; total stall = 2 + (cycles to 4 acks).
- A miss still asserted at the first IDLE edge after SETTLE starts a new refill. The cache deasserts miss once the line hits.

## Test plan
- Basic refill: reset, miss=1 with address=0x1235, mem_ack=1 constant, mem_rdata = 0xA0000000 + mem_addr. Required: mem_addr sequence 0x1234..0x1237; write for 1 cycle with data1..data4 = 0xA0001234..0xA0001237; stall 6 cycles; fill_count=1.
- Wait states: mem_ack high every third cycle. Required:
  - mem_req held continuously
  - mem_addr advances only after each ack
  - captured words match
  - total stall = 2 + 12 cycles
- Block at top of memory: miss with address=0x7FFE. Required: mem_addr 0x7FFC..0x7FFF, no wrap to 0x0000.
- Ignored inputs:
  - mem_ack pulses while IDLE
  - miss toggling during FETCH/SETTLE
  - address changed mid-refill
  Required: no extra refill, base unchanged, fill_count increments by exactly 1 per refill.
- Reset mid-refill: assert rst after the second ack. Required, immediately: stall=0, mem_req=0, data1..data4=0, fill_count=0, no write pulse. The next miss restarts cleanly from idx 0.
- Counter saturation: run with CNT_W=2, 5 refills. Required: fill_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cache_fill_ctrl_if.sv
// Refill controller bus bundle: cache-side miss/address inputs, the
// single-word memory read handshake, and the block write-back outputs.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              miss;
  logic [ADDR_W-1:0] address;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [DATA_W-1:0] data4;
  logic              write;
  logic              stall;
  logic              busy;
  logic [CNT_W-1:0]  fill_count;

  // Controller side
  modport master (
    input  miss, address, mem_ack, mem_rdata,
    output mem_req, mem_addr, data1, data2, data3, data4,
           write, stall, busy, fill_count
  );

  // Cache / memory side
  modport slave (
    output miss, address, mem_ack, mem_rdata,
    input  mem_req, mem_addr, data1, data2, data3, data4,
           write, stall, busy, fill_count
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache refill engine: on a miss, fetch the aligned 4-word block one word
// per memory handshake, then strobe all four words into the cache at once.
// The processor is stalled from the miss until one cycle after the write.
module cache_fill_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, SETTLE} state_t;

  state_t                       state;
  logic [1:0]                   idx;
  // Only the block-aligned part of the base is stored; the low two bits
  // of every fetch address come from idx, so a block can never carry
  // into the index field.
  logic [ADDR_W-3:0]            base_hi;
  logic [3:0][DATA_W-1:0]       words;
  logic [CNT_W-1:0]             fill_count;

  // Refill sequencing, word capture and saturating refill counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      base_hi    <= '0;
      words      <= '0;
      fill_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss) begin
            base_hi <= bus.address[ADDR_W-1:2];
            idx     <= 2'd0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          // Slots are overwritten one at a time; untouched slots keep the
          // previous block until their word arrives.
          if (bus.mem_ack) begin
            words[idx] <= bus.mem_rdata;
            if (idx == 2'd3) state <= WRITE;
            else             idx   <= idx + 2'd1;
          end
        end
        WRITE: begin
          if (fill_count != '1) fill_count <= fill_count + CNT_W'(1);
          state <= SETTLE;
        end
        SETTLE: begin
          // Gives the cache one cycle to see the hit before miss is
          // sampled again.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.stall      = (state != IDLE);
  assign bus.mem_req    = (state == FETCH);
  assign bus.mem_addr   = (state == FETCH) ? {base_hi, idx} : '0;
  assign bus.write      = (state == WRITE);
  assign bus.data1      = words[0];
  assign bus.data2      = words[1];
  assign bus.data3      = words[2];
  assign bus.data4      = words[3];
  assign bus.fill_count = fill_count;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl. Stimulus pushes expected fetch
// addresses, block contents, counts and stall lengths; a negedge monitor
// pops and compares whenever the DUT shows a handshake, write or stall end.
// A second instance with a 2-bit counter shares all inputs to observe
// counter saturation.
module tb_cache_fill_ctrl;

  typedef struct {
    logic [31:0] d [4];
    logic [15:0] c16;
    logic [1:0]  c2;
  } wr_exp_t;

  logic clk;
  logic rst;

  cache_fill_ctrl_if #(.ADDR_W(15), .DATA_W(32), .CNT_W(16)) b1 ();
  cache_fill_ctrl_if #(.ADDR_W(15), .DATA_W(32), .CNT_W(2))  b2 ();

  cache_fill_ctrl #(.ADDR_W(15), .DATA_W(32), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (b1.master));
  cache_fill_ctrl #(.ADDR_W(15), .DATA_W(32), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (b2.master));

  int n_chk  = 0;
  int n_pass = 0;
  int fills  = 0;

  logic [14:0] exp_addr [$];
  wr_exp_t     exp_wr   [$];
  int          exp_stall[$];

  // memory model: data = 0xA0000000 + address, ack constant or every third
  // cycle of an outstanding request
  int ack_mode  = 0;
  logic ack_force = 1'b0;
  int ph = 0;
  always @(posedge clk) ph <= b1.mem_req ? ph + 1 : 0;
  assign b1.mem_ack   = (ack_mode == 2) ? (ph % 3 == 2) : ack_force;
  assign b1.mem_rdata = 32'hA000_0000 + {17'd0, b1.mem_addr};
  assign b2.mem_ack   = b1.mem_ack;
  assign b2.mem_rdata = 32'hA000_0000 + {17'd0, b2.mem_addr};
  assign b2.miss      = b1.miss;
  assign b2.address   = b1.address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor state
  int run = 0, reqn = 0;
  bit gap = 0, seen_nonreq = 0, cnt_pend = 0;
  logic [15:0] pend_c16;
  logic [1:0]  pend_c2;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      run = 0; reqn = 0; gap = 0; seen_nonreq = 0; cnt_pend = 0;
    end else begin
      if (cnt_pend) begin
        chk("cnt16", 64'(b1.fill_count), 64'(pend_c16));
        chk("cnt2",  64'(b2.fill_count), 64'(pend_c2));
        cnt_pend = 0;
      end
      if (b1.mem_req && b1.mem_ack) begin
        if (exp_addr.size() == 0) chk("unexpected_ack", 64'(b1.mem_addr), 64'h1_0000);
        else chk("addr", 64'(b1.mem_addr), 64'(exp_addr.pop_front()));
      end
      if (b1.write) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 64'(b1.write), 64'd0);
        else begin
          wr_exp_t e;
          e = exp_wr.pop_front();
          chk("data1", 64'(b1.data1), 64'(e.d[0]));
          chk("data2", 64'(b1.data2), 64'(e.d[1]));
          chk("data3", 64'(b1.data3), 64'(e.d[2]));
          chk("data4", 64'(b1.data4), 64'(e.d[3]));
          pend_c16 = e.c16; pend_c2 = e.c2; cnt_pend = 1;
        end
      end
      if (b1.stall) begin
        run++;
        if (b1.mem_req) begin
          if (seen_nonreq) gap = 1;
          reqn++;
        end else seen_nonreq = 1;
      end else if (run != 0) begin
        if (exp_stall.size() == 0) chk("unexpected_stall", 64'(run), 64'd0);
        else begin
          int s;
          s = exp_stall.pop_front();
          chk("stall_len", 64'(run), 64'(s));
          chk("req_len",   64'(reqn), 64'(s - 2));
          chk("req_gap",   64'(gap), 64'd0);
        end
        run = 0; reqn = 0; gap = 0; seen_nonreq = 0;
      end
    end
  end

  // One full refill. mode 1: ack every cycle, mode 2: ack every third cycle.
  // wiggle toggles miss and scrambles address while the refill is busy.
  task automatic refill(input logic [14:0] a, input int mode, input bit wiggle);
    logic [14:0] b;
    wr_exp_t e;
    bit done;
    b = {a[14:2], 2'b00};
    @(posedge clk); #1;
    ack_mode  = mode;
    ack_force = 1'b1;
    b1.miss    = 1'b1;
    b1.address = a;
    fills++;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(b + 15'(i));
      e.d[i] = 32'hA000_0000 + {17'd0, b} + 32'(i);
    end
    e.c16 = 16'(fills);
    e.c2  = (fills >= 3) ? 2'd3 : 2'(fills);
    exp_wr.push_back(e);
    exp_stall.push_back(mode == 2 ? 14 : 6);
    @(posedge clk); #1;
    if (!wiggle) b1.miss = 1'b0;
    done = 0;
    for (int k = 0; k < 100; k++) begin
      if (!b1.stall) begin done = 1; break; end
      if (wiggle) begin
        b1.miss    = ~b1.miss;
        b1.address = 15'($urandom);
      end
      @(posedge clk); #1;
    end
    b1.miss = 1'b0;
    if (!done) chk("refill_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    b1.miss = 1'b0;
    b1.address = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_stall",   64'(b1.stall),   64'd0);
    chk("rst_busy",    64'(b1.busy),    64'd0);
    chk("rst_req",     64'(b1.mem_req), 64'd0);
    chk("rst_maddr",   64'(b1.mem_addr), 64'd0);
    chk("rst_write",   64'(b1.write),   64'd0);
    chk("rst_data",    {b1.data1, b1.data2} | {b1.data3, b1.data4}, 64'd0);
    chk("rst_cnt",     64'(b1.fill_count), 64'd0);
    rst = 1'b0;

    // basic, wait states, top of memory
    refill(15'h1235, 1, 0);
    refill(15'h0A53, 2, 0);
    refill(15'h7FFE, 1, 0);

    // mem_ack pulses while idle must not start anything
    ack_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ack_force = i[0];
    end
    chk("idle_ack_stall", 64'(b1.stall), 64'd0);
    chk("idle_ack_cnt",   64'(b1.fill_count), 64'd3);

    // miss toggling / address scrambled mid-refill
    refill(15'h2222, 1, 1);
    chk("ign_cnt", 64'(b1.fill_count), 64'd4);

    // reset after the second ack
    @(posedge clk); #1;
    ack_mode = 1; ack_force = 1'b1;
    b1.miss = 1'b1; b1.address = 15'h0456;
    exp_addr.push_back(15'h0454);
    exp_addr.push_back(15'h0455);
    @(posedge clk); #1;           // E0: FETCH
    b1.miss = 1'b0;
    @(posedge clk);               // E1: first ack
    @(posedge clk); #1;           // E2: second ack
    rst = 1'b1;
    #1;
    chk("mid_stall", 64'(b1.stall),   64'd0);
    chk("mid_req",   64'(b1.mem_req), 64'd0);
    chk("mid_write", 64'(b1.write),   64'd0);
    chk("mid_data",  {b1.data1, b1.data2} | {b1.data3, b1.data4}, 64'd0);
    chk("mid_cnt",   64'(b1.fill_count), 64'd0);
    chk("mid_cnt2",  64'(b2.fill_count), 64'd0);
    chk("mid_acks",  64'(exp_addr.size()), 64'd0);
    exp_addr.delete();
    fills = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // five refills after reset: 2-bit counter reads 1,2,3,3,3
    refill(15'h0003, 1, 0);
    refill(15'h4ABC, 2, 0);
    refill(15'h3FFF, 1, 0);
    refill(15'h0000, 1, 0);
    refill(15'h5555, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("left_addr",  64'(exp_addr.size()),  64'd0);
    chk("left_write", 64'(exp_wr.size()),    64'd0);
    chk("left_stall", 64'(exp_stall.size()), 64'd0);
    chk("end_cnt",    64'(b1.fill_count),    64'd5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
